// File: rtl/exe_pkg.sv
// Shared types and constants for the execute stage: control-word layout,
// immediate formats, ALU and muldiv opcodes, and the muldiv sequencer states.
package exe_pkg;

    localparam int CW_ASEL    = 0;
    localparam int CW_BSEL    = 1;
    localparam int CW_MODSEL  = 2;
    localparam int CW_IMM_LO  = 3;
    localparam int CW_IMM_HI  = 5;
    localparam int CW_JUMP    = 6;
    localparam int CW_BRANCH  = 7;
    localparam int CW_DCTL_LO = 8;
    localparam int CW_DCTL_HI = 12;
    localparam int CW_MULDIV  = 13;

    typedef enum logic [2:0] {
        IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4
    } imm_sel_e;

    typedef enum logic [2:0] {
        MD_MUL = 3'd0, MD_MULH = 3'd1, MD_MULHSU = 3'd2, MD_MULHU = 3'd3,
        MD_DIV = 3'd4, MD_DIVU = 3'd5, MD_REM    = 3'd6, MD_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} exe_state_e;

    // {alternate bit, funct3}
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SLL = 4'd1, ALU_SLT = 4'd2, ALU_SLTU = 4'd3,
        ALU_XOR = 4'd4, ALU_SRL = 4'd5, ALU_OR  = 4'd6, ALU_AND  = 4'd7,
        ALU_SUB = 4'd8, ALU_SRA = 4'd13
    } alu_op_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] i, input logic [2:0] sel);
        case (sel)
            IMM_S:   imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_J:   imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            IMM_U:   imm_gen = {i[31:12], 12'b0};
            default: imm_gen = {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU for RV32I-style register and immediate operations.
import exe_pkg::*;

module alu #(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] sh;
    assign sh = b[SW-1:0];

    always_comb begin
        y = a + b;
        case (alu_op_e'(op))
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << sh;
            ALU_SLT:  y = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: y = XLEN'(a < b);
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> sh;
            ALU_SRA:  y = XLEN'($signed(a) >>> sh);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = a + b;
        endcase
    end
endmodule

// File: rtl/execute_stage_m_muldiv.sv
// Iterative radix-2 RV32M unit: shift-add multiply and restoring divide on
// operand magnitudes, with the result sign applied when the sequence completes.
import exe_pkg::*;

module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic            invalidate,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            idle,
    output logic            running,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    exe_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q;
    muldiv_op_e      op_q;
    logic [XLEN-1:0] hi_q, lo_q, b_q, a_q;
    logic            neg_q, bzero_q;

    logic            sa, sb;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   sum, rem_sh, diff;
    logic [2*XLEN-1:0] prod_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (invalidate) state_d = S_IDLE;
        else if (clk_en) begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_RUN;
                S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign idle    = (state_q == S_IDLE);
    assign running = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);

    always_comb begin
        sa    = (op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & a[XLEN-1];
        sb    = (op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM}) & b[XLEN-1];
        a_mag = sa ? -a : a;
        b_mag = sb ? -b : b;
    end

    // hi/lo double as {product high, multiplier} or {remainder, quotient}
    assign sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign rem_sh = {hi_q, lo_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, b_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            op_q    <= MD_MUL;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            a_q     <= '0;
            neg_q   <= 1'b0;
            bzero_q <= 1'b0;
        end else if (invalidate) begin
            cnt_q <= '0;
        end else if (clk_en) begin
            if (idle && start) begin
                cnt_q   <= '0;
                op_q    <= muldiv_op_e'(op);
                hi_q    <= '0;
                lo_q    <= op[2] ? a_mag : b_mag;
                b_q     <= op[2] ? b_mag : a_mag;
                a_q     <= a;
                neg_q   <= (op == MD_REM || op == MD_REMU) ? sa : (sa ^ sb);
                bzero_q <= (b == '0);
            end else if (running) begin
                cnt_q <= cnt_q + 1'b1;
                if (!op_q[2]) begin
                    hi_q <= sum[XLEN:1];
                    lo_q <= {sum[0], lo_q[XLEN-1:1]};
                end else if (!diff[XLEN]) begin
                    hi_q <= diff[XLEN-1:0];
                    lo_q <= {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_q <= rem_sh[XLEN-1:0];
                    lo_q <= {lo_q[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    assign prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

    always_comb begin
        case (op_q)
            MD_MUL:               result = prod_s[XLEN-1:0];
            MD_DIV, MD_DIVU:      result = bzero_q ? '1 : (neg_q ? -lo_q : lo_q);
            MD_REM, MD_REMU:      result = bzero_q ? a_q : (neg_q ? -hi_q : hi_q);
            default:              result = prod_s[2*XLEN-1:XLEN];
        endcase
    end
endmodule

// File: rtl/execute_stage_m.sv
// Execute stage: single-cycle ALU/branch path plus an iterative muldiv unit
// that stalls upstream and emits bubbles until its result retires.
import exe_pkg::*;

module execute_stage_m #(
    parameter int XLEN = 32,
    parameter int PCW  = XLEN - 2
) (
    input  logic            clk,
    input  logic            async_rst_n,
    input  logic            clk_en,
    input  logic            invalidate,
    input  logic [31:0]     inst_in,
    input  logic [13:0]     ctr_word_in,
    input  logic [XLEN-1:0] regfile_rs1,
    input  logic [XLEN-1:0] regfile_rs2,
    input  logic [PCW-1:0]  pc_in,
    output logic [4:0]      ctr_out,
    output logic [31:0]     inst_out,
    output logic [XLEN-1:0] alu_out,
    output logic [PCW-1:0]  inc_pc_out,
    output logic [XLEN-1:0] regfile_rs2_out,
    output logic            branch_result_out,
    output logic [4:0]      exe_rs1_address,
    output logic [4:0]      exe_rs2_address,
    output logic            exe_uses_rs1,
    output logic            exe_uses_rs2,
    output logic            exe_busy
);
    logic            asel, bsel, modsel, jump, branch, muldiv;
    logic [2:0]      fn3;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x, op_a, op_b, alu_y, md_result;
    logic [3:0]      alu_op;
    logic            cmp, br_taken;
    logic            md_idle, md_run, md_done;

    assign asel   = ctr_word_in[CW_ASEL];
    assign bsel   = ctr_word_in[CW_BSEL];
    assign modsel = ctr_word_in[CW_MODSEL];
    assign jump   = ctr_word_in[CW_JUMP];
    assign branch = ctr_word_in[CW_BRANCH];
    assign muldiv = ctr_word_in[CW_MULDIV];
    assign fn3    = inst_in[14:12];

    assign exe_rs1_address = inst_in[19:15];
    assign exe_rs2_address = inst_in[24:20];
    assign exe_uses_rs1    = !asel | branch | muldiv;
    assign exe_uses_rs2    = !bsel | branch | muldiv;

    assign imm32 = imm_gen(inst_in, ctr_word_in[CW_IMM_HI:CW_IMM_LO]);

    // Sign-extend (or truncate) the 32-bit immediate to the datapath width
    always_comb begin
        imm_x = '0;
        for (int i = 0; i < XLEN; i++) imm_x[i] = imm32[(i < 32) ? i : 31];
    end

    assign op_a = asel ? XLEN'({pc_in, 2'b00}) : regfile_rs1;
    assign op_b = bsel ? imm_x : regfile_rs2;

    // inst[30] selects SUB only for register-register adds, SRA for any right shift
    assign alu_op = modsel ? ALU_ADD
                  : {inst_in[30] & ((fn3 == 3'd5) | ((fn3 == 3'd0) & !bsel)), fn3};

    alu #(.XLEN(XLEN)) u_alu (
        .op (alu_op),
        .a  (op_a),
        .b  (op_b),
        .y  (alu_y)
    );

    always_comb begin
        case (fn3[2:1])
            2'd0:    cmp = (regfile_rs1 == regfile_rs2);
            2'd2:    cmp = ($signed(regfile_rs1) < $signed(regfile_rs2));
            2'd3:    cmp = (regfile_rs1 < regfile_rs2);
            default: cmp = fn3[0];
        endcase
    end

    assign br_taken = ((cmp ^ fn3[0]) & branch) | jump;

    muldiv_unit #(.XLEN(XLEN)) u_md (
        .clk        (clk),
        .rst_n      (async_rst_n),
        .clk_en     (clk_en),
        .invalidate (invalidate),
        .start      (muldiv),
        .op         (fn3),
        .a          (regfile_rs1),
        .b          (regfile_rs2),
        .idle       (md_idle),
        .running    (md_run),
        .done       (md_done),
        .result     (md_result)
    );

    // Not busy in DONE, so upstream advances on the edge the result retires
    assign exe_busy = (md_idle & muldiv) | md_run;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            ctr_out           <= '0;
            inst_out          <= '0;
            alu_out           <= '0;
            inc_pc_out        <= '0;
            regfile_rs2_out   <= '0;
            branch_result_out <= 1'b0;
        end else if (invalidate) begin
            ctr_out           <= '0;
            branch_result_out <= 1'b0;
        end else if (clk_en) begin
            if (exe_busy) begin
                ctr_out           <= '0;
                branch_result_out <= 1'b0;
            end else begin
                ctr_out           <= ctr_word_in[CW_DCTL_HI:CW_DCTL_LO];
                inst_out          <= inst_in;
                alu_out           <= md_done ? md_result : alu_y;
                inc_pc_out        <= pc_in + PCW'(1);
                regfile_rs2_out   <= regfile_rs2;
                branch_result_out <= md_done ? 1'b0 : br_taken;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage_m.sv
// Directed bench for execute_stage_m: ALU/branch ops, muldiv results, latency,
// stall, flush and asynchronous reset behaviour.
module tb_execute_stage_m;
    logic        clk = 1'b0;
    logic        async_rst_n, clk_en, invalidate;
    logic [31:0] inst_in;
    logic [13:0] ctr_word_in;
    logic [31:0] regfile_rs1, regfile_rs2;
    logic [29:0] pc_in;
    logic [4:0]  ctr_out;
    logic [31:0] inst_out, alu_out, regfile_rs2_out;
    logic [29:0] inc_pc_out;
    logic        branch_result_out;
    logic [4:0]  exe_rs1_address, exe_rs2_address;
    logic        exe_uses_rs1, exe_uses_rs2, exe_busy;

    int checks = 0;
    int errors = 0;

    execute_stage_m dut (
        .clk               (clk),
        .async_rst_n       (async_rst_n),
        .clk_en            (clk_en),
        .invalidate        (invalidate),
        .inst_in           (inst_in),
        .ctr_word_in       (ctr_word_in),
        .regfile_rs1       (regfile_rs1),
        .regfile_rs2       (regfile_rs2),
        .pc_in             (pc_in),
        .ctr_out           (ctr_out),
        .inst_out          (inst_out),
        .alu_out           (alu_out),
        .inc_pc_out        (inc_pc_out),
        .regfile_rs2_out   (regfile_rs2_out),
        .branch_result_out (branch_result_out),
        .exe_rs1_address   (exe_rs1_address),
        .exe_rs2_address   (exe_rs2_address),
        .exe_uses_rs1      (exe_uses_rs1),
        .exe_uses_rs2      (exe_uses_rs2),
        .exe_busy          (exe_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] cw(input bit asel, input bit bsel, input bit md_mod,
                                       input logic [2:0] imm, input bit j, input bit br,
                                       input logic [4:0] d, input bit md);
        return {md, d, br, j, imm, md_mod, bsel, asel};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rr(input logic [2:0] f3, input bit alt, input logic [31:0] a,
                          input logic [31:0] b, input logic [13:0] c);
        inst_in     = {1'b0, alt, 5'd0, 5'd2, 5'd1, f3, 5'd3, 7'h33};
        ctr_word_in = c;
        regfile_rs1 = a;
        regfile_rs2 = b;
    endtask

    // Present one muldiv op and run until it retires; stall_at >= 0 drops clk_en for 3 cycles
    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int stall_at);
        int n = 0, bub = 0, busy = 0;
        bit got = 0;
        set_rr(f3, 1'b0, a, b, cw(0, 0, 0, 3'd0, 0, 0, 5'h05, 1));
        inst_in[25] = 1'b1;
        while (!got && n < 100) begin
            clk_en = !(stall_at >= 0 && n >= stall_at && n < stall_at + 3);
            #1;
            if (exe_busy && clk_en) busy++;
            tick();
            n++;
            if (ctr_out != 5'd0) got = 1;
            else if (clk_en) bub++;
        end
        clk_en = 1'b1;
        chk({tag, " latency"}, n, (stall_at >= 0) ? 37 : 34);
        chk({tag, " busy"}, busy, 33);
        chk({tag, " bubbles"}, bub, 33);
        chk({tag, " result"}, alu_out, exp);
        chk({tag, " ctr"}, 32'(ctr_out), 32'h05);
        chk({tag, " br"}, 32'(branch_result_out), 32'h0);
    endtask

    initial begin
        async_rst_n = 1'b0;
        clk_en      = 1'b0;
        invalidate  = 1'b0;
        inst_in     = '0;
        ctr_word_in = '0;
        regfile_rs1 = '0;
        regfile_rs2 = '0;
        pc_in       = '0;
        #22;
        chk("rst ctr", 32'(ctr_out), 32'h0);
        chk("rst alu", alu_out, 32'h0);
        chk("rst pc", 32'(inc_pc_out), 32'h0);
        chk("rst br", 32'(branch_result_out), 32'h0);
        async_rst_n = 1'b1;
        tick();

        // ADDI x1,x0,5
        inst_in     = 32'h0050_0093;
        ctr_word_in = cw(0, 1, 0, 3'd0, 0, 0, 5'h13, 0);
        regfile_rs1 = 32'h0;
        regfile_rs2 = 32'hDEAD_BEEF;
        pc_in       = 30'h10;
        clk_en      = 1'b1;
        #1;
        chk("addi busy", 32'(exe_busy), 32'h0);
        chk("addi rs2addr", 32'(exe_rs2_address), 32'h5);
        chk("addi uses_rs2", 32'(exe_uses_rs2), 32'h0);
        chk("addi uses_rs1", 32'(exe_uses_rs1), 32'h1);
        tick();
        chk("addi alu", alu_out, 32'h5);
        chk("addi ctr", 32'(ctr_out), 32'h13);
        chk("addi inst", inst_out, 32'h0050_0093);
        chk("addi pc", 32'(inc_pc_out), 32'h11);

        // ADD / SUB register-register
        set_rr(3'd0, 1'b0, 32'd10, 32'd3, cw(0, 0, 0, 3'd0, 0, 0, 5'h01, 0));
        tick();
        chk("add alu", alu_out, 32'd13);
        chk("add rs2", regfile_rs2_out, 32'd3);
        set_rr(3'd0, 1'b1, 32'd10, 32'd3, cw(0, 0, 0, 3'd0, 0, 0, 5'h01, 0));
        tick();
        chk("sub alu", alu_out, 32'd7);

        // Branch compares: BLTU, BLT, BGE, BNE
        set_rr(3'd6, 1'b0, 32'hFFFF_FFFF, 32'd1, cw(1, 1, 1, 3'd2, 0, 1, 5'h02, 0));
        inst_in[6:0] = 7'h63;
        #1;
        chk("br uses_rs2", 32'(exe_uses_rs2), 32'h1);
        tick();
        chk("bltu", 32'(branch_result_out), 32'h0);
        inst_in[14:12] = 3'd4;
        tick();
        chk("blt", 32'(branch_result_out), 32'h1);
        inst_in[14:12] = 3'd5;
        tick();
        chk("bge", 32'(branch_result_out), 32'h0);
        inst_in[14:12] = 3'd1;
        regfile_rs1 = 32'd1;
        tick();
        chk("bne equal", 32'(branch_result_out), 32'h0);

        // JAL: PC-relative target and taken flag
        inst_in     = 32'h0080_006F;
        ctr_word_in = cw(1, 1, 1, 3'd3, 1, 0, 5'h04, 0);
        pc_in       = 30'h100;
        tick();
        chk("jal target", alu_out, 32'h408);
        chk("jal taken", 32'(branch_result_out), 32'h1);
        chk("jal pc", 32'(inc_pc_out), 32'h101);

        // PC increment wraps
        set_rr(3'd0, 1'b0, 32'd1, 32'd1, cw(0, 0, 0, 3'd0, 0, 0, 5'h01, 0));
        pc_in = 30'h3FFF_FFFF;
        tick();
        chk("pc wrap", 32'(inc_pc_out), 32'h0);

        run_md("mul",    3'd0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, -1);
        run_md("mulhu",  3'd3, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002, -1);
        run_md("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, -1);
        run_md("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, -1);
        run_md("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1);
        run_md("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, -1);
        run_md("divu z", 3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, -1);
        run_md("remu z", 3'd7, 32'd7, 32'd0, 32'd7, -1);
        run_md("div neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, -1);
        run_md("rem neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, -1);
        run_md("div z",  3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, -1);
        run_md("rem z",  3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, -1);
        run_md("divu",   3'd5, 32'd100, 32'd7, 32'd14, -1);
        run_md("remu",   3'd7, 32'd100, 32'd7, 32'd2, -1);
        run_md("mul stall", 3'd0, 32'd6, 32'd7, 32'd42, 10);

        // Flush a DIV on RUN edge 10, then a plain ADD retires in one edge
        set_rr(3'd4, 1'b0, 32'd100, 32'd7, cw(0, 0, 0, 3'd0, 0, 0, 5'h05, 1));
        inst_in[25] = 1'b1;
        tick();
        repeat (10) tick();
        chk("div inflight ctr", 32'(ctr_out), 32'h0);
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        set_rr(3'd0, 1'b0, 32'd10, 32'd3, cw(0, 0, 0, 3'd0, 0, 0, 5'h1F, 0));
        #1;
        chk("inv busy", 32'(exe_busy), 32'h0);
        chk("inv ctr", 32'(ctr_out), 32'h0);
        chk("inv br", 32'(branch_result_out), 32'h0);
        tick();
        chk("post-inv add", alu_out, 32'd13);
        chk("post-inv ctr", 32'(ctr_out), 32'h1F);

        // Asynchronous reset in the middle of a MUL
        set_rr(3'd0, 1'b0, 32'd5, 32'd5, cw(0, 0, 0, 3'd0, 0, 0, 5'h05, 1));
        inst_in[25] = 1'b1;
        repeat (5) tick();
        async_rst_n = 1'b0;
        #1;
        chk("midrst alu", alu_out, 32'h0);
        chk("midrst pc", 32'(inc_pc_out), 32'h0);
        #2;
        async_rst_n = 1'b1;
        ctr_word_in = cw(0, 0, 0, 3'd0, 0, 0, 5'h00, 0);
        #1;
        chk("midrst busy", 32'(exe_busy), 32'h0);
        run_md("mul after rst", 3'd0, 32'd5, 32'd5, 32'd25, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
